// File: rtl/idma_data_fifo_drain_ctrl.sv
// Destination-side drain sequencer for the iDMA dual-clock data FIFO.
// Optional stall counter: define IDMA_DRAIN_PERF_CNT_EN.
module idma_data_fifo_drain_ctrl #(
    parameter int FIFO_WIDTH   = 288,
    parameter int FIFO_CNT_WID = 7,
    parameter int LEN_W        = 8,
    parameter int BURST_MIN    = 4,
    parameter int FLUSH_CYC    = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    flush_req,
    output logic                    fifo_pop,
    input  logic [FIFO_WIDTH-1:0]   fifo_data,
    input  logic                    fifo_empty,
    input  logic [FIFO_CNT_WID-1:0] fifo_word_cnt,
    output logic                    fifo_init,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FIFO_WIDTH-2:0]   out_data,
    output logic                    out_last,
    output logic                    done,
    output logic                    err_last,
    output logic                    busy,
    output logic [31:0]             perf_stall_cnt
);

    localparam int REM_W = LEN_W + 1;
    localparam int FC_W  = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        XFER  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [REM_W-1:0]      rem_q;
    logic [REM_W-1:0]      pops_q;
    logic [REM_W-1:0]      pops_nxt;
    logic [REM_W-1:0]      thr;
    logic [FC_W-1:0]       fcnt_q;
    logic                  stage_v_q;
    logic                  last_q;
    logic                  err_q;
    logic [FIFO_WIDTH-2:0] data_q;

    logic cmd_hs;
    logic acc;
    logic pops_left;
    logic is_final;
    logic occ_ok;
    logic pop_en;
    logic xfer_done;
    logic flush_end;

    assign cmd_hs    = cmd_valid & cmd_ready;
    assign acc       = stage_v_q & out_ready;
    assign pops_nxt  = pops_q + REM_W'(1);
    assign pops_left = pops_q < rem_q;
    assign is_final  = pops_nxt == rem_q;
    assign thr       = (rem_q < REM_W'(BURST_MIN)) ? rem_q : REM_W'(BURST_MIN);
    assign occ_ok    = 32'(fifo_word_cnt) >= 32'(thr);
    assign xfer_done = (state_q == XFER) & ~pops_left & ~stage_v_q;
    assign flush_end = fcnt_q == FC_W'(FLUSH_CYC - 1);
    assign pop_en    = (state_q == XFER) & ~flush_req & ~fifo_empty
                     & (~stage_v_q | acc) & pops_left;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_req) begin
            state_d = FLUSH;
        end else begin
            unique case (state_q)
                IDLE:    if (cmd_hs)    state_d = WAIT;
                WAIT:    if (occ_ok)    state_d = XFER;
                XFER:    if (xfer_done) state_d = IDLE;
                FLUSH:   if (flush_end) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // rstn gates cmd_ready so nothing is accepted while reset is held
    always_comb begin
        cmd_ready = rstn & (state_q == IDLE) & ~flush_req;
        fifo_pop  = pop_en;
        fifo_init = state_q == FLUSH;
        done      = xfer_done & ~flush_req;
        busy      = (state_q != IDLE) | stage_v_q;
        out_valid = stage_v_q;
        out_data  = data_q;
        out_last  = last_q;
        err_last  = err_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q     <= '0;
            pops_q    <= '0;
            fcnt_q    <= '0;
            stage_v_q <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else if (flush_req) begin
            rem_q     <= '0;
            pops_q    <= '0;
            fcnt_q    <= '0;
            stage_v_q <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            if (cmd_hs) begin
                rem_q  <= REM_W'(cmd_len) + REM_W'(1);
                pops_q <= '0;
            end
            if (state_q == FLUSH) begin
                fcnt_q <= fcnt_q + FC_W'(1);
            end
            if (pop_en) begin
                data_q    <= fifo_data[FIFO_WIDTH-2:0];
                last_q    <= is_final;
                stage_v_q <= 1'b1;
                pops_q    <= pops_nxt;
                if (fifo_data[FIFO_WIDTH-1] != is_final) begin
                    err_q <= 1'b1;
                end
            end else if (acc) begin
                stage_v_q <= 1'b0;
                last_q    <= 1'b0;
            end
        end
    end

`ifdef IDMA_DRAIN_PERF_CNT_EN
    logic [31:0] perf_q;
    logic        stall;

    assign stall = (state_q == XFER)
                 & ((stage_v_q & ~out_ready)
                 | (~stage_v_q & fifo_empty & pops_left));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_q <= '0;
        end else if (flush_req) begin
            perf_q <= '0;
        end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_idma_data_fifo_drain_ctrl.sv
// Bench for idma_data_fifo_drain_ctrl: queue-based FIFO and beat scoreboard.
// Inputs change at negedge, outputs are sampled 1ns later.
module tb_idma_data_fifo_drain_ctrl;

    localparam int W  = 288;
    localparam int CW = 7;
    localparam int LW = 8;
    localparam int FLUSH_CYC = 4;
    localparam int BURST_MIN = 4;

    typedef logic [W-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic          flush_req = 1'b0;
    logic          fifo_pop;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic [CW-1:0] fifo_word_cnt = '0;
    logic          fifo_init;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-2:0]  out_data;
    logic          out_last;
    logic          done;
    logic          err_last;
    logic          busy;
    logic [31:0]   perf_stall_cnt;

    idma_data_fifo_drain_ctrl dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .flush_req(flush_req), .fifo_pop(fifo_pop), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_word_cnt(fifo_word_cnt),
        .fifo_init(fifo_init), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .done(done),
        .err_last(err_last), .busy(busy), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO contents and beats still owed downstream, in push order
    ent_t fq[$];
    ent_t ep[$];

    // transaction-level model: 0 idle, 1 command open, 2 flushing
    int ph, m_n, m_pops, m_acc, fl_left;
    bit m_err, done_nx;
    bit stall_prev, flush_prev;
    logic [W-2:0] prev_data;
    logic [31:0] perf_prev;

    int rdy_mode, rdy_ph, push_mode, push_left, pcnt;
    int cyc;
    int n_pop, n_acc, n_last, n_done, n_init, n_stall, n_badpop;
    int first_pop_cyc, first_pop_wc, first_val_cyc, last_acc_cyc, done_cyc;
    int pop2_cyc, err_cyc, run, max_run;

    task automatic push(input bit flag);
        ent_t e;
        for (int k = 0; k < 9; k++) e[k*32 +: 32] = $urandom;
        e[W-1] = flag;
        fq.push_back(e);
        ep.push_back(e);
    endtask

    task automatic model_reset();
        ph = 0; m_n = 0; m_pops = 0; m_acc = 0; fl_left = 0;
        m_err = 0; done_nx = 0; stall_prev = 0; flush_prev = 0;
        perf_prev = 0;
        fq.delete(); ep.delete();
    endtask

    task automatic clr_obs();
        n_pop = 0; n_acc = 0; n_last = 0; n_done = 0; n_init = 0;
        n_stall = 0; n_badpop = 0; run = 0; max_run = 0;
        first_pop_cyc = -1; first_pop_wc = -1; first_val_cyc = -1;
        last_acc_cyc = -1; done_cyc = -1; pop2_cyc = -1; err_cyc = -1;
    endtask

    task automatic tick();
        bit pop, acc, fin, dn;
        int wc, thr;
        unique case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = (rdy_ph % 3) == 0;
            default: out_ready = 1'b1;
        endcase
        rdy_ph++;
        if (push_left > 0) begin
            if ((push_mode == 1 && pcnt % 4 == 0) ||
                (push_mode == 2 && $urandom_range(0, 1) == 1)) begin
                push(push_left == 1);
                push_left--;
            end
        end
        pcnt++;
        fifo_empty    = fq.size() == 0;
        fifo_word_cnt = (fq.size() > 127) ? 7'd127 : CW'(fq.size());
        fifo_data     = (fq.size() != 0) ? fq[0] : '0;
        #1;
        if (rstn) begin
            pop = fifo_pop;
            acc = out_valid & out_ready;
            dn  = done;
            wc  = int'(fifo_word_cnt);
            checks++;
            if (cmd_ready !== ((ph == 0) && !flush_req)) begin
                errors++;
                $display("FAIL cmd_ready cyc=%0d got=%b", cyc, cmd_ready);
            end
            checks++;
            if (fifo_init !== (ph == 2)) begin
                errors++;
                $display("FAIL fifo_init cyc=%0d got=%b", cyc, fifo_init);
            end
            checks++;
            if (out_valid !== (m_pops - m_acc == 1)) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got=%b held=%0d",
                         cyc, out_valid, m_pops - m_acc);
            end
            checks++;
            if (busy !== ((ph != 0) || (m_pops - m_acc == 1))) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b", cyc, busy);
            end
            checks++;
            if (done !== (done_nx && !flush_req)) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b exp=%b",
                         cyc, done, done_nx && !flush_req);
            end
            checks++;
            if (err_last !== m_err) begin
                errors++;
                $display("FAIL err_last cyc=%0d got=%b exp=%b",
                         cyc, err_last, m_err);
            end
            thr = (m_n < BURST_MIN) ? m_n : BURST_MIN;
            if (pop && !flush_req) begin
                checks++;
                if (fifo_empty || ph != 1 || m_pops >= m_n ||
                    (m_pops == 0 && wc < thr)) begin
                    errors++;
                    $display("FAIL pop_legal cyc=%0d wc=%0d pops=%0d n=%0d",
                             cyc, wc, m_pops, m_n);
                end
            end
            if (acc) begin
                checks++;
                if (ep.size() == 0 || out_data !== ep[0][W-2:0]) begin
                    errors++;
                    $display("FAIL beat_data cyc=%0d got=%h", cyc, out_data);
                end
                checks++;
                if (out_last !== (m_acc + 1 == m_n)) begin
                    errors++;
                    $display("FAIL beat_last cyc=%0d got=%b beat=%0d n=%0d",
                             cyc, out_last, m_acc + 1, m_n);
                end
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got=%h exp=%h",
                             cyc, out_data, prev_data);
                end
            end
`ifdef IDMA_DRAIN_PERF_CNT_EN
            checks++;
            if (flush_prev ? (perf_stall_cnt !== 32'd0)
                           : (perf_stall_cnt < perf_prev)) begin
                errors++;
                $display("FAIL perf cyc=%0d got=%0d prev=%0d",
                         cyc, perf_stall_cnt, perf_prev);
            end
            perf_prev  = perf_stall_cnt;
`else
            checks++;
            if (perf_stall_cnt !== 32'd0) begin
                errors++;
                $display("FAIL perf cyc=%0d got=%0d exp=0", cyc, perf_stall_cnt);
            end
`endif
            flush_prev = flush_req;
            stall_prev = out_valid && !out_ready && !flush_req;
            prev_data  = out_data;
            if (pop) begin
                n_pop++;
                if (first_pop_cyc < 0) begin
                    first_pop_cyc = cyc;
                    first_pop_wc  = wc;
                end
                if (n_pop == 2) pop2_cyc = cyc;
                run++;
                if (run > max_run) max_run = run;
                if (out_valid && !out_ready) n_badpop++;
            end else begin
                run = 0;
            end
            if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (out_valid && !out_ready) n_stall++;
            if (err_last && err_cyc < 0) err_cyc = cyc;
            if (acc) begin
                n_acc++;
                last_acc_cyc = cyc;
                if (out_last) n_last++;
            end
            if (dn) begin
                n_done++;
                done_cyc = cyc;
            end
            if (fifo_init) n_init++;
            if (flush_req) begin
                ph = 2; fl_left = FLUSH_CYC;
                m_err = 0; m_pops = 0; m_acc = 0; m_n = 0; done_nx = 0;
                fq.delete(); ep.delete();
            end else if (ph == 0) begin
                if (cmd_valid && cmd_ready) begin
                    ph = 1; m_n = int'(cmd_len) + 1; m_pops = 0; m_acc = 0;
                end
                done_nx = 0;
            end else if (ph == 1) begin
                if (done_nx) ph = 0;
                done_nx = 0;
                if (pop) begin
                    fin = (m_pops + 1 == m_n);
                    if (fifo_data[W-1] != fin) m_err = 1;
                    m_pops++;
                    void'(fq.pop_front());
                end
                if (acc) begin
                    void'(ep.pop_front());
                    m_acc++;
                    if (m_acc == m_n) done_nx = 1;
                end
            end else begin
                fl_left--;
                if (fl_left == 0) ph = 0;
                done_nx = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = n_done;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done > d0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic start_cmd(input int len);
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_ready, fifo_pop, fifo_init, out_valid, out_last,
             done, err_last, busy} !== 8'b0 || out_data !== '0 ||
            perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b", {cmd_ready, fifo_pop,
                     fifo_init, out_valid, out_last, done, err_last, busy});
        end
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        clr_obs();
        tick();
        checks++;
        if (n_pop !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got pops=%0d busy=%b", n_pop, busy);
        end
    endtask

    task automatic test_basic_burst();
        bit ok;
        clr_obs();
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) push(i == 7);
        start_cmd(7);
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got=timeout exp=done");
        end
        checks++;
        if (max_run !== 8 || n_pop !== 8) begin
            errors++;
            $display("FAIL basic_pop_run got=%0d/%0d exp=8", max_run, n_pop);
        end
        checks++;
        if (first_val_cyc !== first_pop_cyc + 1) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=%0d",
                     first_val_cyc, first_pop_cyc + 1);
        end
        checks++;
        if (done_cyc !== last_acc_cyc + 1 || n_acc !== 8 || n_last !== 1) begin
            errors++;
            $display("FAIL basic_frame got done=%0d acc=%0d beats=%0d last=%0d",
                     done_cyc, last_acc_cyc, n_acc, n_last);
        end
        checks++;
        if (err_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got=%b exp=0", err_last);
        end
    endtask

    task automatic test_occupancy_gate();
        bit ok;
        clr_obs();
        rdy_mode = 0;
        push_mode = 1; push_left = 16; pcnt = 0;
        start_cmd(15);
        wait_done(200, ok);
        push_mode = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL gate_done got=timeout exp=done");
        end
        checks++;
        if (first_pop_wc !== 4) begin
            errors++;
            $display("FAIL gate_first_pop_cnt got=%0d exp=4", first_pop_wc);
        end
        checks++;
        if (n_pop !== 16 || n_acc !== 16 || n_last !== 1) begin
            errors++;
            $display("FAIL gate_beats got pops=%0d beats=%0d last=%0d exp=16",
                     n_pop, n_acc, n_last);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clr_obs();
        rdy_mode = 2; rdy_ph = 0;
        for (int i = 0; i < 4; i++) push(i == 3);
        start_cmd(3);
        wait_done(60, ok);
        rdy_mode = 0;
        checks++;
        if (!ok || n_acc !== 4 || n_last !== 1) begin
            errors++;
            $display("FAIL bp_beats got ok=%b beats=%0d last=%0d exp=4",
                     ok, n_acc, n_last);
        end
        checks++;
        if (n_stall == 0 || n_badpop !== 0) begin
            errors++;
            $display("FAIL bp_stall got stalls=%0d bad_pops=%0d",
                     n_stall, n_badpop);
        end
    endtask

    task automatic test_last_mismatch();
        bit ok;
        clr_obs();
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) push(i == 1);
        start_cmd(3);
        wait_done(60, ok);
        checks++;
        if (!ok || n_acc !== 4 || n_last !== 1) begin
            errors++;
            $display("FAIL mm_beats got ok=%b beats=%0d last=%0d exp=4",
                     ok, n_acc, n_last);
        end
        checks++;
        if (err_cyc !== pop2_cyc + 1) begin
            errors++;
            $display("FAIL mm_err_rise got=%0d exp=%0d", err_cyc, pop2_cyc + 1);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (err_last !== 1'b1) begin
            errors++;
            $display("FAIL mm_sticky got=%b exp=1", err_last);
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        checks++;
        if (err_last !== 1'b0) begin
            errors++;
            $display("FAIL mm_clear got=%b exp=0", err_last);
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_flush_mid_burst();
        int i0, d0;
        clr_obs();
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) push(i == 15);
        start_cmd(15);
        for (int i = 0; i < 60 && n_acc < 5; i++) tick();
        checks++;
        if (n_acc !== 5) begin
            errors++;
            $display("FAIL flush_reach got=%0d exp=5", n_acc);
        end
        i0 = n_init; d0 = n_done;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid got=%b exp=0", out_valid);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (n_init - i0 !== 4 || n_done !== d0) begin
            errors++;
            $display("FAIL flush_init got=%0d done=%0d exp=4/0",
                     n_init - i0, n_done - d0);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        clr_obs();
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) push(i == 15);
        start_cmd(15);
        for (int i = 0; i < 60 && n_acc < 3; i++) tick();
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, fifo_pop, fifo_init, out_valid, out_last,
             done, err_last, busy} !== 8'b0 || out_data !== '0 ||
            perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got=%b", {cmd_ready, fifo_pop,
                     fifo_init, out_valid, out_last, done, err_last, busy});
        end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        clr_obs();
        push(1'b1);
        start_cmd(0);
        wait_done(20, ok);
        checks++;
        if (!ok || n_acc !== 1 || n_last !== 1) begin
            errors++;
            $display("FAIL post_reset got ok=%b beats=%0d last=%0d exp=1",
                     ok, n_acc, n_last);
        end
    endtask

    task automatic test_random();
        bit ok;
        int len;
        for (int c = 0; c < 8; c++) begin
            clr_obs();
            len = $urandom_range(0, 15);
            rdy_mode = 1;
            push_mode = 2; push_left = len + 1;
            start_cmd(len);
            wait_done(400, ok);
            checks++;
            if (!ok || n_acc !== len + 1 || n_last !== 1 || err_last !== 1'b0) begin
                errors++;
                $display("FAIL rand_cmd%0d got ok=%b beats=%0d last=%0d err=%b exp=%0d",
                         c, ok, n_acc, n_last, err_last, len + 1);
            end
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end
        rdy_mode = 0; push_mode = 0; push_left = 0;
    endtask

    initial begin
        cyc = 0; rdy_mode = 0; rdy_ph = 0; push_mode = 0;
        push_left = 0; pcnt = 0;
        model_reset();
        clr_obs();
        test_reset();
        test_basic_burst();
        test_occupancy_gate();
        test_backpressure();
        test_last_mismatch();
        test_flush_mid_burst();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idma_data_fifo_drain_ctrl.md
Name: idma_data_fifo_drain_ctrl

Overview:
- Destination-side sequencer for the iDMA dual-clock data FIFO; sits in the clk domain on the FIFO pop port.
- Accepts burst commands (beat count), waits for enough FIFO occupancy, pops entries into a 1-deep registered output stage, and generates beat/last framing.
- Checks the FIFO's embedded last flag against its own beat count.
- Owns the FIFO destination-side init (flush) pulse.

Parameters:
- FIFO_WIDTH, 288, FIFO entry width; bit FIFO_WIDTH-1 is the write-side last flag, bits FIFO_WIDTH-2:0 are payload.
- FIFO_CNT_WID, 7, width of the FIFO word count.
- LEN_W, 8, command length field width, AXI-style (beats-1).
- BURST_MIN, 4, minimum FIFO occupancy before streaming starts.
- FLUSH_CYC, 4, number of cycles fifo_init is held during a flush.

Ports:
- clk  in  1  destination clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_len  in  LEN_W  beats-1.
- flush_req  in  1  single-cycle request to abort and flush.
- fifo_pop  out  1  pop strobe to the FIFO.
- fifo_data  in  FIFO_WIDTH  FIFO head entry; show-ahead, valid when !fifo_empty.
- fifo_empty  in  1  FIFO empty.
- fifo_word_cnt  in  FIFO_CNT_WID  FIFO occupancy.
- fifo_init  out  1  FIFO destination-side init, active high.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  FIFO_WIDTH-1  payload.
- out_last  out  1  final beat of the command.
- done  out  1  one-cycle pulse when the last beat is accepted downstream.
- err_last  out  1  sticky last-flag mismatch; cleared only by flush or reset.
- busy  out  1  state != IDLE or output stage full.
- perf_stall_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (async, rstn=0) drives every output to 0: state=IDLE, output stage empty, counters 0, cmd_ready=0 in the reset cycle.
- States:
  - IDLE: cmd_ready=1. On handshake, latch rem=cmd_len+1 (width LEN_W+1) and go to WAIT.
  - WAIT: go to XFER when fifo_word_cnt >= min(rem, BURST_MIN); this compare uses the full remaining count.
  - XFER: pop_en = !fifo_empty & (stage empty | (out_valid & out_ready)) & (pops_issued < rem_total); fifo_pop=pop_en.
    - On a pop, the stage loads payload and out_last=(pop is the rem-th pop).
    - Once all pops are issued and the stage drains (last beat accepted): pulse done and go to IDLE.
    - The next command is not accepted in the same cycle as done.
  - FLUSH: fifo_init=1 for FLUSH_CYC cycles, then go to IDLE.
- Output stage:
  - out_valid rises the cycle after a pop. Latency from FIFO head to out_valid is 1 clk.
  - Payload is held stable while out_valid & !out_ready.
  - Full throughput: 1 beat/clk with out_ready=1 and the FIFO non-empty.
- Last check on each pop:
  - err_last sets if flag=1 on a non-final pop.
  - err_last sets if flag=0 on the final pop.
  - The transfer continues regardless; out_last always comes from the counter.
- Single-beat command (cmd_len=0): WAIT needs only fifo_word_cnt >= 1.
- FIFO underrun mid-burst (fifo_empty=1 in XFER): no pop and no error; the stage drains normally.
- flush_req:
  - Has priority over any other event in any state, including in the same cycle as cmd handshake or done.
  - Clears the output stage, counters and err_last immediately (out_valid=0 next cycle), with no done pulse.
  - Then enters FLUSH.
  - A flush_req during FLUSH restarts the FLUSH_CYC count.
- fifo_pop is never asserted while fifo_empty=1, in FLUSH, or in IDLE/WAIT.

Optional Feature:
- Macro: IDMA_DRAIN_PERF_CNT_EN.
- Defined: perf_stall_cnt is a 32-bit counter, reset to 0, cleared on flush_req. It increments every XFER cycle in which either condition holds:
  - out_valid & !out_ready, or
  - stage empty & fifo_empty & pops outstanding.
  - It saturates at 0xFFFF_FFFF.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Basic burst: FIFO preloaded with 8 entries (last flag on the 8th), cmd_len=7, out_ready=1 -> fifo_pop high 8 consecutive cycles; out_valid for 8 cycles starting 1 clk after the first pop; out_last on beat 8; done 1 cycle after beat 8 is accepted; err_last=0.
- Occupancy gate: cmd_len=15 with FIFO filled one entry per 4 cycles -> no pop until fifo_word_cnt=4; after that, pops follow the arrivals; 16 beats total.
- Backpressure: cmd_len=3, out_ready toggles 1,0,0,1,... -> out_data held stable while out_ready=0; exactly 4 beats; no pop while the stage is full and out_ready=0.
- Last mismatch: cmd_len=3 with the flag set on entry 2 -> err_last=1 after the 2nd pop; 4 beats still delivered; out_last on beat 4; err_last stays 1 until flush_req.
- Flush mid-burst: cmd_len=15, flush_req at beat 5 -> out_valid=0 next cycle; fifo_init=1 for exactly 4 cycles; no done pulse; back in IDLE with cmd_ready=1.
- Reset mid-burst: rstn=0 asynchronously during XFER -> all outputs 0 immediately; after release, the block is IDLE and a new cmd_len=0 completes in 1 beat.
